// File: rtl/mem_stage.sv
// RV32 memory stage: EX/MEM -> data bus request/grant/response -> MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_STAGE_MISALIGN_CHECK_EN.

package rv32_pkg;
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        valid;
  } ex_mem_pipeline_reg_t;
endpackage

module mem_stage
  import rv32_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  ex_mem_pipeline_reg_t ex_mem_i,
  output logic                 stall_o,
  output logic [31:0]          mem_fwd_data_o,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  output logic [31:0]          data_addr_o,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [31:0]          data_wdata_o,
  input  logic                 data_rvalid_i,
  input  logic [31:0]          data_rdata_i,
  output logic [31:0]          mem_wb_alu_result_o,
  output logic [31:0]          mem_wb_load_data_o,
  output logic [4:0]           mem_wb_rd_addr_o,
  output logic                 mem_wb_reg_write_o,
  output logic                 mem_wb_mem_read_o,
  output logic                 mem_wb_valid_o,
  output logic                 mem_wb_misalign_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_t;

  state_t state, state_next;
  logic   memop;
  logic   misalign;
  logic   issue;
  logic   complete;

  assign memop = ex_mem_i.valid & (ex_mem_i.mem_read | ex_mem_i.mem_write);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  // Misaligned accesses never reach the bus; they retire flagged instead.
  assign misalign    = memop & (ex_mem_i.alu_result[1:0] != 2'b00);
  assign data_addr_o = ex_mem_i.alu_result;
`else
  assign misalign    = 1'b0;
  assign data_addr_o = {ex_mem_i.alu_result[31:2], 2'b00};
`endif

  assign issue          = memop & ~misalign;
  assign complete       = (state == WAIT_RVALID) & data_rvalid_i;
  assign stall_o        = issue & ~complete;
  assign mem_fwd_data_o = ex_mem_i.alu_result;
  assign data_we_o      = ex_mem_i.mem_write;
  assign data_be_o      = 4'hF;
  assign data_wdata_o   = ex_mem_i.rs2_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    data_req_o = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          data_req_o = 1'b1;
          state_next = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_GNT: begin
        data_req_o = 1'b1;
        if (data_gnt_i) begin
          state_next = WAIT_RVALID;
        end else begin
          state_next = WAIT_GNT;
        end
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_RVALID;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A stalled cycle emits a bubble but keeps the payload of the last retired op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_wb_alu_result_o <= 32'h0000_0000;
      mem_wb_load_data_o  <= 32'h0000_0000;
      mem_wb_rd_addr_o    <= 5'd0;
      mem_wb_reg_write_o  <= 1'b0;
      mem_wb_mem_read_o   <= 1'b0;
      mem_wb_valid_o      <= 1'b0;
      mem_wb_misalign_o   <= 1'b0;
    end else if (stall_o) begin
      mem_wb_valid_o      <= 1'b0;
    end else begin
      mem_wb_alu_result_o <= ex_mem_i.alu_result;
      mem_wb_load_data_o  <= (complete & ex_mem_i.mem_read) ? data_rdata_i : 32'h0000_0000;
      mem_wb_rd_addr_o    <= ex_mem_i.rd_addr;
      mem_wb_reg_write_o  <= ex_mem_i.reg_write & ~misalign;
      mem_wb_mem_read_o   <= ex_mem_i.mem_read;
      mem_wb_valid_o      <= ex_mem_i.valid;
      mem_wb_misalign_o   <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: vector table plus multi-cycle sequences.

module tb_mem_stage;
  import rv32_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  ex_mem_pipeline_reg_t ex_mem_i;
  logic                 stall_o;
  logic [31:0]          mem_fwd_data_o;
  logic                 data_req_o;
  logic                 data_gnt_i;
  logic [31:0]          data_addr_o;
  logic                 data_we_o;
  logic [3:0]           data_be_o;
  logic [31:0]          data_wdata_o;
  logic                 data_rvalid_i;
  logic [31:0]          data_rdata_i;
  logic [31:0]          mem_wb_alu_result_o;
  logic [31:0]          mem_wb_load_data_o;
  logic [4:0]           mem_wb_rd_addr_o;
  logic                 mem_wb_reg_write_o;
  logic                 mem_wb_mem_read_o;
  logic                 mem_wb_valid_o;
  logic                 mem_wb_misalign_o;

  int checks = 0;
  int failures = 0;

  mem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .ex_mem_i(ex_mem_i), .stall_o(stall_o),
    .mem_fwd_data_o(mem_fwd_data_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .mem_wb_alu_result_o(mem_wb_alu_result_o), .mem_wb_load_data_o(mem_wb_load_data_o),
    .mem_wb_rd_addr_o(mem_wb_rd_addr_o), .mem_wb_reg_write_o(mem_wb_reg_write_o),
    .mem_wb_mem_read_o(mem_wb_mem_read_o), .mem_wb_valid_o(mem_wb_valid_o),
    .mem_wb_misalign_o(mem_wb_misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        v;
    logic        exp_req;
    logic        exp_stall;
    logic        exp_wb_valid;
    logic        exp_wb_rw;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic v);
    ex_mem_i.alu_result = alu;
    ex_mem_i.rs2_data   = rs2;
    ex_mem_i.rd_addr    = rd;
    ex_mem_i.reg_write  = rw;
    ex_mem_i.mem_read   = mr;
    ex_mem_i.mem_write  = mw;
    ex_mem_i.valid      = v;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int req_cnt;
    int stall_cnt;
    rst_i = 1'b1;
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i = 32'h0;
    nop();

    // alu, rd, rw, mr, mw, v, exp_req, exp_stall, exp_wb_valid, exp_wb_rw
    vecs[0] = '{32'h0000_0042, 5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{32'h1234_5670, 5'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0500, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0600, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    step();
    check("rst_req", {31'd0, data_req_o}, 32'd0);
    check("rst_wb_valid", {31'd0, mem_wb_valid_o}, 32'd0);
    check("rst_wb_alu", mem_wb_alu_result_o, 32'd0);
    check("rst_wb_rd", {27'd0, mem_wb_rd_addr_o}, 32'd0);
    check("rst_wb_misalign", {31'd0, mem_wb_misalign_o}, 32'd0);
    rst_i = 1'b0;
    step();

    // Non-memops and invalid memops: single-cycle pass, no request
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].alu, 32'hCAFE_0000, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].v);
      #1;
      check($sformatf("vec%0d_req", i), {31'd0, data_req_o}, {31'd0, vecs[i].exp_req});
      check($sformatf("vec%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].exp_stall});
      check($sformatf("vec%0d_fwd", i), mem_fwd_data_o, vecs[i].alu);
      step();
      check($sformatf("vec%0d_wb_valid", i), {31'd0, mem_wb_valid_o}, {31'd0, vecs[i].exp_wb_valid});
      check($sformatf("vec%0d_wb_rw", i), {31'd0, mem_wb_reg_write_o}, {31'd0, vecs[i].exp_wb_rw});
      check($sformatf("vec%0d_wb_alu", i), mem_wb_alu_result_o, vecs[i].alu);
      check($sformatf("vec%0d_wb_rd", i), {27'd0, mem_wb_rd_addr_o}, {27'd0, vecs[i].rd});
    end

    // Load 0x100, grant same cycle, response next cycle
    drive(32'h0000_0100, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    data_gnt_i = 1'b1;
    #1;
    check("ld_req", {31'd0, data_req_o}, 32'd1);
    check("ld_addr", data_addr_o, 32'h0000_0100);
    check("ld_we", {31'd0, data_we_o}, 32'd0);
    check("ld_be", {28'd0, data_be_o}, 32'hF);
    check("ld_stall0", {31'd0, stall_o}, 32'd1);
    step();
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hDEAD_BEEF;
    #1;
    check("ld_req_off", {31'd0, data_req_o}, 32'd0);
    check("ld_stall1", {31'd0, stall_o}, 32'd0);
    check("ld_bubble", {31'd0, mem_wb_valid_o}, 32'd0);
    step();
    data_rvalid_i = 1'b0;
    nop();
    check("ld_wb_valid", {31'd0, mem_wb_valid_o}, 32'd1);
    check("ld_wb_data", mem_wb_load_data_o, 32'hDEAD_BEEF);
    check("ld_wb_rd", {27'd0, mem_wb_rd_addr_o}, 32'd3);
    check("ld_wb_mr", {31'd0, mem_wb_mem_read_o}, 32'd1);

    // Store 0x200: grant after 3 wait cycles, response 2 cycles after grant
    drive(32'h0000_0200, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    req_cnt = 0;
    stall_cnt = 0;
    data_rdata_i = 32'h5555_5555;
    for (int c = 0; c < 6; c++) begin
      data_gnt_i = (c == 3);
      data_rvalid_i = (c == 5);
      #1;
      if (data_req_o) begin
        req_cnt++;
        check($sformatf("st_addr_c%0d", c), data_addr_o, 32'h0000_0200);
        check($sformatf("st_wdata_c%0d", c), data_wdata_o, 32'h1234_5678);
        check($sformatf("st_we_c%0d", c), {31'd0, data_we_o}, 32'd1);
      end
      if (stall_o) stall_cnt++;
      if (c > 0) check($sformatf("st_bubble_c%0d", c), {31'd0, mem_wb_valid_o}, 32'd0);
      step();
    end
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    check("st_req_cycles", req_cnt, 32'd4);
    check("st_stall_cycles", stall_cnt, 32'd5);
    check("st_wb_valid", {31'd0, mem_wb_valid_o}, 32'd1);
    check("st_wb_load_data", mem_wb_load_data_o, 32'd0);
    check("st_wb_mr", {31'd0, mem_wb_mem_read_o}, 32'd0);

    // ALU op then load back to back
    drive(32'h0000_0042, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check("b2b_alu_stall", {31'd0, stall_o}, 32'd0);
    step();
    drive(32'h0000_0300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    check("b2b_wb_alu", mem_wb_alu_result_o, 32'h0000_0042);
    check("b2b_wb_rd", {27'd0, mem_wb_rd_addr_o}, 32'd5);
    check("b2b_wb_valid", {31'd0, mem_wb_valid_o}, 32'd1);
    check("b2b_ld_req", {31'd0, data_req_o}, 32'd1);
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'h0000_0303;
    step();
    data_rvalid_i = 1'b0;
    nop();
    check("b2b_ld_data", mem_wb_load_data_o, 32'h0000_0303);

    // Reset while waiting for a response; late response must be dropped
    drive(32'h0000_0400, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    rst_i = 1'b1;
    nop();
    #1;
    check("rst_mid_req", {31'd0, data_req_o}, 32'd0);
    check("rst_mid_wb_valid", {31'd0, mem_wb_valid_o}, 32'd0);
    check("rst_mid_wb_alu", mem_wb_alu_result_o, 32'd0);
    step();
    rst_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hAAAA_5555;
    #1;
    check("rst_late_stall", {31'd0, stall_o}, 32'd0);
    step();
    data_rvalid_i = 1'b0;
    check("rst_late_data", mem_wb_load_data_o, 32'd0);
    check("rst_late_mr", {31'd0, mem_wb_mem_read_o}, 32'd0);
    drive(32'h0000_0404, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    check("rst_first_req", {31'd0, data_req_o}, 32'd1);
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'h0000_0404;
    step();
    data_rvalid_i = 1'b0;
    nop();
    check("rst_first_data", mem_wb_load_data_o, 32'h0000_0404);

    // Spurious response in IDLE
    drive(32'h0000_0077, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hFFFF_FFFF;
    #1;
    check("spur_stall", {31'd0, stall_o}, 32'd0);
    step();
    data_rvalid_i = 1'b0;
    check("spur_wb_data", mem_wb_load_data_o, 32'd0);
    check("spur_wb_alu", mem_wb_alu_result_o, 32'h0000_0077);
    drive(32'h0000_0500, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    check("spur_idle_req", {31'd0, data_req_o}, 32'd1);
    check("spur_idle_stall", {31'd0, stall_o}, 32'd1);
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'h0000_0500;
    step();
    data_rvalid_i = 1'b0;
    nop();
    check("spur_after_data", mem_wb_load_data_o, 32'h0000_0500);

    // Misaligned load 0x102
    drive(32'h0000_0102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    check("mis_req", {31'd0, data_req_o}, 32'd0);
    check("mis_stall", {31'd0, stall_o}, 32'd0);
    step();
    nop();
    check("mis_wb_flag", {31'd0, mem_wb_misalign_o}, 32'd1);
    check("mis_wb_rw", {31'd0, mem_wb_reg_write_o}, 32'd0);
    check("mis_wb_valid", {31'd0, mem_wb_valid_o}, 32'd1);
`else
    check("mis_req", {31'd0, data_req_o}, 32'd1);
    check("mis_addr", data_addr_o, 32'h0000_0100);
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'h0000_0102;
    step();
    data_rvalid_i = 1'b0;
    nop();
    check("mis_wb_flag", {31'd0, mem_wb_misalign_o}, 32'd0);
    check("mis_wb_rw", {31'd0, mem_wb_reg_write_o}, 32'd1);
    check("mis_wb_data", mem_wb_load_data_o, 32'h0000_0102);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
